// File: rtl/pfetch_req_buf_if.sv
// ----------------------------------------------------------------------------
// pfetch_req_buf_if
//   Bundles the prefetch request buffer's allocation, selector, memory and
//   fill signals. The buffer itself connects through the 'slave' modport and
//   the surrounding environment (prefetcher, selector, memory, I-cache, or a
//   testbench standing in for them) through the 'master' modport.
//
// Handshake semantics:
//   - Allocation: alloc_en_i/alloc_addr_i are a request that is taken in any
//     cycle where full_o is 0 (full_o plays the role of !ready). With the
//     duplicate filter built in, a duplicate request is also consumed, but it
//     allocates nothing.
//   - Memory command: mem_cmd_valid_o/mem_addr_o form the valid side. A
//     nonzero mem_tag_i in the same cycle is the ready/accept, and it names
//     the tag the response will carry. A zero tag means not accepted, so the
//     command is offered again later.
//   - Response: a nonzero mem_resp_tag_i is a one-cycle, always-accepted
//     strobe with mem_resp_data_i.
//   - Fill: fill_valid_o is a one-cycle strobe with no back-pressure.
//
// Signals:
//   alloc_en_i, alloc_addr_i   prefetcher allocation request
//   full_o                     no free entry this cycle
//   req_o, ptr_o               request vector / priority pointer to selector
//   gnt_i                      one-hot (or zero) grant from selector
//   mem_cmd_valid_o, mem_addr_o, mem_tag_i   memory load command
//   mem_resp_tag_i, mem_resp_data_i          memory response
//   fill_valid_o, fill_addr_o, fill_data_o   registered I-cache fill
//   dbg_state_o                per-entry state, 2 bits per entry
//                              (0 INVALID, 1 WAIT_GNT, 2 WAIT_MEM)
// ----------------------------------------------------------------------------
interface pfetch_req_buf_if #(
    parameter int NUM_ENTRIES = 8,
    parameter int PTR_W       = $clog2(NUM_ENTRIES),
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TAG_W       = 4
);
    logic                     alloc_en_i;
    logic [ADDR_W-1:0]        alloc_addr_i;
    logic                     full_o;
    logic [NUM_ENTRIES-1:0]   req_o;
    logic [PTR_W-1:0]         ptr_o;
    logic [NUM_ENTRIES-1:0]   gnt_i;
    logic                     mem_cmd_valid_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [TAG_W-1:0]         mem_tag_i;
    logic [TAG_W-1:0]         mem_resp_tag_i;
    logic [DATA_W-1:0]        mem_resp_data_i;
    logic                     fill_valid_o;
    logic [ADDR_W-1:0]        fill_addr_o;
    logic [DATA_W-1:0]        fill_data_o;
    logic [2*NUM_ENTRIES-1:0] dbg_state_o;

    modport slave (
        input  alloc_en_i, alloc_addr_i, gnt_i, mem_tag_i, mem_resp_tag_i, mem_resp_data_i,
        output full_o, req_o, ptr_o, mem_cmd_valid_o, mem_addr_o,
               fill_valid_o, fill_addr_o, fill_data_o, dbg_state_o
    );

    modport master (
        output alloc_en_i, alloc_addr_i, gnt_i, mem_tag_i, mem_resp_tag_i, mem_resp_data_i,
        input  full_o, req_o, ptr_o, mem_cmd_valid_o, mem_addr_o,
               fill_valid_o, fill_addr_o, fill_data_o, dbg_state_o
    );
endinterface

// File: rtl/pfetch_req_buf.sv
// ----------------------------------------------------------------------------
// pfetch_req_buf
//   This is an eight-entry prefetch request buffer. Each entry moves through
//   three states: INVALID, then WAIT_GNT (address held, requesting the
//   selector), then WAIT_MEM (memory tag held, awaiting the response).
//   Allocation goes to the lowest-index free entry. A grant that memory
//   accepts (nonzero tag) moves an entry to WAIT_MEM and advances the
//   selector pointer past it. A response whose tag matches a WAIT_MEM entry
//   frees that entry and produces a registered fill.
//
// Configuration macro:
//   PFETCH_DUP_CHECK_EN - when defined, an allocation is dropped if its
//   address matches any entry that is not INVALID. That set includes the
//   entry retiring this cycle, because it is still WAIT_MEM in registered
//   state.
//
// Ports:
//   clock  single clock
//   reset  synchronous, active-high
//   bus    pfetch_req_buf_if.slave (see interface file for signal list)
// ----------------------------------------------------------------------------
module pfetch_req_buf #(
    parameter int NUM_ENTRIES = 8,
    parameter int PTR_W       = $clog2(NUM_ENTRIES),
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TAG_W       = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    pfetch_req_buf_if.slave       bus
);
    typedef enum logic [1:0] {
        ST_INVALID  = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_MEM = 2'd2
    } entry_state_e;

    // Registered state
    entry_state_e           state_q [NUM_ENTRIES];
    entry_state_e           state_d [NUM_ENTRIES];
    logic [ADDR_W-1:0]      addr_q  [NUM_ENTRIES];
    logic [ADDR_W-1:0]      addr_d  [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_q   [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_d   [NUM_ENTRIES];
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   fill_valid_q, fill_valid_d;
    logic [ADDR_W-1:0]      fill_addr_q, fill_addr_d;
    logic [DATA_W-1:0]      fill_data_q, fill_data_d;

    // Decoded current-cycle view
    logic [NUM_ENTRIES-1:0]   req;
    logic [NUM_ENTRIES-1:0]   issue_vec;
    logic                     full;
    logic [ADDR_W-1:0]        issue_addr;
    logic [2*NUM_ENTRIES-1:0] dbg_state;

    // Next-state helpers
    logic                   alloc_found;
    logic [PTR_W-1:0]       alloc_idx;
    logic                   dup_hit;
    logic                   issue_accept;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= ST_INVALID;
                addr_q[i]  <= '0;
                tag_q[i]   <= '0;
            end
            ptr_q        <= '0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                addr_q[i]  <= addr_d[i];
                tag_q[i]   <= tag_d[i];
            end
            ptr_q        <= ptr_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_data_q  <= fill_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode: everything the selector and memory see this cycle is
    // derived from registered state, so a freshly allocated entry cannot be
    // issued in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        req        = '0;
        full       = 1'b1;
        issue_addr = '0;
        dbg_state  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            req[i] = (state_q[i] == ST_WAIT_GNT);
            if (state_q[i] == ST_INVALID) begin
                full = 1'b0;
            end
            dbg_state[2*i +: 2] = state_q[i];
        end
        // Grants to entries that are not requesting are ignored.
        issue_vec = bus.gnt_i & req;
        // AND-OR mux. With a legal one-hot grant, exactly one term survives.
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (issue_vec[i]) begin
                issue_addr = issue_addr | addr_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Allocation targets INVALID entries, issue targets
    // WAIT_GNT entries and retirement targets WAIT_MEM entries, so all three
    // can land in one cycle without touching the same entry.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
            tag_d[i]   = tag_q[i];
        end
        ptr_d        = ptr_q;
        fill_valid_d = 1'b0;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;
        alloc_found  = 1'b0;
        alloc_idx    = '0;
        dup_hit      = 1'b0;
        issue_accept = (|issue_vec) && (bus.mem_tag_i != '0);

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!alloc_found && state_q[i] == ST_INVALID) begin
                alloc_found = 1'b1;
                alloc_idx   = PTR_W'(i);
            end
`ifdef PFETCH_DUP_CHECK_EN
            if (state_q[i] != ST_INVALID && addr_q[i] == bus.alloc_addr_i) begin
                dup_hit = 1'b1;
            end
`endif
        end

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            // Tag 0 never names a live request, so a zero response tag
            // cannot retire anything.
            if (state_q[i] == ST_WAIT_MEM && bus.mem_resp_tag_i != '0 &&
                tag_q[i] == bus.mem_resp_tag_i) begin
                state_d[i]   = ST_INVALID;
                fill_valid_d = 1'b1;
                fill_addr_d  = addr_q[i];
                fill_data_d  = bus.mem_resp_data_i;
            end
            if (issue_accept && issue_vec[i]) begin
                state_d[i] = ST_WAIT_MEM;
                tag_d[i]   = bus.mem_tag_i;
                ptr_d      = (i == NUM_ENTRIES - 1) ? '0 : PTR_W'(i + 1);
            end
        end

        if (bus.alloc_en_i && alloc_found && !dup_hit) begin
            state_d[alloc_idx] = ST_WAIT_GNT;
            addr_d[alloc_idx]  = bus.alloc_addr_i;
        end
    end

    assign bus.req_o           = req;
    assign bus.full_o          = full;
    assign bus.ptr_o           = ptr_q;
    assign bus.mem_cmd_valid_o = |issue_vec;
    assign bus.mem_addr_o      = issue_addr;
    assign bus.fill_valid_o    = fill_valid_q;
    assign bus.fill_addr_o     = fill_addr_q;
    assign bus.fill_data_o     = fill_data_q;
    assign bus.dbg_state_o     = dbg_state;

endmodule

// File: tb/tb_pfetch_req_buf.sv
// ----------------------------------------------------------------------------
// tb_pfetch_req_buf
//   This testbench drives the prefetch request buffer through directed
//   scenarios followed by a randomized run. It keeps a reference model of
//   the buffer contents: per-slot busy/issued flags, address, tag and
//   pointer. The model is advanced on every clock and compared with the DUT
//   outputs at the falling edge.
// ----------------------------------------------------------------------------
module tb_pfetch_req_buf;
    localparam int N      = 8;
    localparam int PTR_W  = 3;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pfetch_req_buf_if #(.NUM_ENTRIES(N), .PTR_W(PTR_W), .ADDR_W(ADDR_W),
                        .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    pfetch_req_buf #(.NUM_ENTRIES(N), .PTR_W(PTR_W), .ADDR_W(ADDR_W),
                     .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model
    bit                m_busy   [N];
    bit                m_issued [N];
    logic [ADDR_W-1:0] m_addr   [N];
    logic [TAG_W-1:0]  m_tag    [N];
    int                m_ptr;
    logic              e_fill_valid;
    logic [ADDR_W-1:0] e_fill_addr;
    logic [DATA_W-1:0] e_fill_data;

    function automatic logic [N-1:0] exp_req();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = m_busy[i] && !m_issued[i];
        return r;
    endfunction

    function automatic logic exp_full();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] exp_mem_addr();
        logic [N-1:0] r;
        r = exp_req();
        for (int i = 0; i < N; i++) if (bus.gnt_i[i] && r[i]) return m_addr[i];
        return '0;
    endfunction

    function automatic bit tag_live(input logic [TAG_W-1:0] t);
        for (int i = 0; i < N; i++) if (m_busy[i] && m_issued[i] && m_tag[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_issued[i] = 0; m_addr[i] = '0; m_tag[i] = '0;
        end
        m_ptr = 0; e_fill_valid = 0; e_fill_addr = '0; e_fill_data = '0;
    endtask

    task automatic drive(input logic en, input logic [ADDR_W-1:0] a, input logic [N-1:0] g,
                         input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] rt,
                         input logic [DATA_W-1:0] rd);
        bus.alloc_en_i = en; bus.alloc_addr_i = a; bus.gnt_i = g;
        bus.mem_tag_i = t; bus.mem_resp_tag_i = rt; bus.mem_resp_data_i = rd;
    endtask

    // Advance one clock: decide the model's next contents from the inputs as
    // they stand before the edge, then apply them once the edge has passed.
    task automatic tick();
        int hit, iss, fi;
        bit dup;
        logic              r_alloc, r_rst;
        logic [ADDR_W-1:0] r_addr;
        logic [TAG_W-1:0]  r_tag;
        logic [DATA_W-1:0] r_data;
        hit = -1; iss = -1; fi = -1; dup = 0;
        r_rst = reset; r_alloc = bus.alloc_en_i; r_addr = bus.alloc_addr_i;
        r_tag = bus.mem_tag_i; r_data = bus.mem_resp_data_i;
        for (int i = 0; i < N; i++) begin
            if (bus.mem_resp_tag_i != 0 && m_busy[i] && m_issued[i] && m_tag[i] == bus.mem_resp_tag_i) hit = i;
            if (bus.gnt_i[i] && m_busy[i] && !m_issued[i]) iss = i;
            if (!m_busy[i] && fi < 0) fi = i;
`ifdef PFETCH_DUP_CHECK_EN
            if (m_busy[i] && m_addr[i] == r_addr) dup = 1;
`endif
        end
        @(posedge clock);
        if (r_rst) begin
            clear_model();
        end else begin
            e_fill_valid = (hit >= 0);
            if (hit >= 0) begin
                e_fill_addr = m_addr[hit]; e_fill_data = r_data; m_busy[hit] = 0; m_issued[hit] = 0;
            end
            if (iss >= 0 && r_tag != 0) begin
                m_issued[iss] = 1; m_tag[iss] = r_tag; m_ptr = (iss + 1) % N;
            end
            if (r_alloc && fi >= 0 && !dup) begin
                m_busy[fi] = 1; m_issued[fi] = 0; m_addr[fi] = r_addr;
            end
        end
        #1;
    endtask

    task automatic idle();
        drive(0, '0, '0, '0, '0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick(); tick();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (bus.req_o !== 8'h00) begin errors++; $display("FAIL reset_req: got %h expected 00", bus.req_o); end
        checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full_o); end
        checks++; if (bus.ptr_o !== 3'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", bus.ptr_o); end
        checks++; if (bus.mem_cmd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b expected 0", bus.mem_cmd_valid_o); end
        checks++; if (bus.fill_valid_o !== 1'b0 || bus.fill_addr_o !== 64'h0 || bus.fill_data_o !== 64'h0) begin
            errors++; $display("FAIL reset_fill: got v=%b a=%h d=%h expected all zero", bus.fill_valid_o, bus.fill_addr_o, bus.fill_data_o);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] d;
        d = {$urandom, $urandom};
        drive(1, 64'h1000, '0, '0, '0, '0);
        @(negedge clock);
        tick();
        drive(0, '0, 8'h01, 4'd3, '0, '0);
        @(negedge clock);
        checks++; if (bus.req_o !== 8'h01) begin errors++; $display("FAIL basic_req: got %h expected 01", bus.req_o); end
        checks++; if (bus.mem_cmd_valid_o !== 1'b1 || bus.mem_addr_o !== 64'h1000) begin
            errors++; $display("FAIL basic_issue: got v=%b a=%h expected v=1 a=1000", bus.mem_cmd_valid_o, bus.mem_addr_o);
        end
        tick();
        idle();
        @(negedge clock);
        checks++; if (bus.ptr_o !== 3'd1) begin errors++; $display("FAIL basic_ptr: got %0d expected 1", bus.ptr_o); end
        checks++; if (bus.req_o !== 8'h00) begin errors++; $display("FAIL basic_req_cleared: got %h expected 00", bus.req_o); end
        tick();
        drive(0, '0, '0, '0, 4'd3, d);
        @(negedge clock);
        checks++; if (bus.fill_valid_o !== 1'b0) begin errors++; $display("FAIL basic_fill_early: got %b expected 0", bus.fill_valid_o); end
        tick();
        idle();
        @(negedge clock);
        checks++; if (bus.fill_valid_o !== 1'b1 || bus.fill_addr_o !== 64'h1000 || bus.fill_data_o !== d) begin
            errors++; $display("FAIL basic_fill: got v=%b a=%h d=%h expected v=1 a=1000 d=%h", bus.fill_valid_o, bus.fill_addr_o, bus.fill_data_o, d);
        end
        tick();
        @(negedge clock);
        checks++; if (bus.fill_valid_o !== 1'b0) begin errors++; $display("FAIL basic_fill_pulse: got %b expected 0", bus.fill_valid_o); end
        checks++; if (bus.dbg_state_o !== 16'h0) begin errors++; $display("FAIL basic_entry_freed: got %h expected 0000", bus.dbg_state_o); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < N; i++) begin
            drive(1, 64'h3000 + 64'(i) * 64'h40, '0, '0, '0, '0);
            @(negedge clock);
            checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL full_fill_%0d: got %b expected 0", i, bus.full_o); end
            tick();
        end
        drive(1, 64'h9000, '0, '0, '0, '0);
        @(negedge clock);
        checks++; if (bus.full_o !== 1'b1 || bus.req_o !== 8'hff) begin
            errors++; $display("FAIL full_set: got full=%b req=%h expected full=1 req=ff", bus.full_o, bus.req_o);
        end
        tick();
        drive(0, '0, 8'h02, 4'd5, '0, '0);
        @(negedge clock);
        checks++; if (bus.mem_addr_o !== 64'h3040 || bus.mem_cmd_valid_o !== 1'b1) begin
            errors++; $display("FAIL full_ninth_ignored: got v=%b a=%h expected v=1 a=3040", bus.mem_cmd_valid_o, bus.mem_addr_o);
        end
        tick();
        drive(0, '0, '0, '0, 4'd5, 64'hdead);
        @(negedge clock);
        checks++; if (bus.full_o !== 1'b1 || bus.req_o !== 8'hfd || bus.ptr_o !== 3'd2) begin
            errors++; $display("FAIL full_after_issue: got full=%b req=%h ptr=%0d expected 1 fd 2", bus.full_o, bus.req_o, bus.ptr_o);
        end
        tick();
        idle();
        @(negedge clock);
        checks++; if (bus.full_o !== 1'b0 || bus.fill_valid_o !== 1'b1 || bus.fill_addr_o !== 64'h3040) begin
            errors++; $display("FAIL full_release: got full=%b fv=%b fa=%h expected 0 1 3040", bus.full_o, bus.fill_valid_o, bus.fill_addr_o);
        end
        tick();
    endtask

    task automatic test_wrap();
        drive(0, '0, 8'h80, 4'd6, '0, '0);
        @(negedge clock);
        checks++; if (bus.mem_cmd_valid_o !== 1'b1 || bus.mem_addr_o !== 64'h31c0) begin
            errors++; $display("FAIL wrap_issue: got v=%b a=%h expected v=1 a=31c0", bus.mem_cmd_valid_o, bus.mem_addr_o);
        end
        tick();
        idle();
        @(negedge clock);
        checks++; if (bus.ptr_o !== 3'd0 || bus.req_o !== 8'h7d) begin
            errors++; $display("FAIL wrap_ptr: got ptr=%0d req=%h expected 0 7d", bus.ptr_o, bus.req_o);
        end
        tick();
    endtask

    task automatic test_tag_zero();
        drive(0, '0, 8'h04, 4'd0, '0, '0);
        @(negedge clock);
        checks++; if (bus.mem_cmd_valid_o !== 1'b1 || bus.mem_addr_o !== 64'h3080) begin
            errors++; $display("FAIL tag0_cmd: got v=%b a=%h expected v=1 a=3080", bus.mem_cmd_valid_o, bus.mem_addr_o);
        end
        tick();
        drive(0, '0, 8'h02, 4'd7, '0, '0);
        @(negedge clock);
        checks++; if (bus.req_o !== 8'h7d || bus.ptr_o !== 3'd0) begin
            errors++; $display("FAIL tag0_hold: got req=%h ptr=%0d expected 7d 0", bus.req_o, bus.ptr_o);
        end
        checks++; if (bus.mem_cmd_valid_o !== 1'b0) begin errors++; $display("FAIL gnt_not_req: got %b expected 0", bus.mem_cmd_valid_o); end
        tick();
        idle();
        @(negedge clock);
        checks++; if (bus.ptr_o !== 3'd0 || bus.req_o !== 8'h7d) begin
            errors++; $display("FAIL gnt_not_req_hold: got ptr=%0d req=%h expected 0 7d", bus.ptr_o, bus.req_o);
        end
        tick();
    endtask

    task automatic test_unknown_tag();
        drive(0, '0, '0, '0, 4'd9, 64'h1234);
        tick();
        idle();
        @(negedge clock);
        checks++; if (bus.fill_valid_o !== 1'b0 || bus.req_o !== 8'h7d || bus.full_o !== 1'b0) begin
            errors++; $display("FAIL unknown_tag: got fv=%b req=%h full=%b expected 0 7d 0", bus.fill_valid_o, bus.req_o, bus.full_o);
        end
        drive(0, '0, '0, '0, 4'd6, 64'h5678);
        tick();
        idle();
        @(negedge clock);
        checks++; if (bus.fill_valid_o !== 1'b1 || bus.fill_addr_o !== 64'h31c0 || bus.fill_data_o !== 64'h5678) begin
            errors++; $display("FAIL entry_kept: got fv=%b fa=%h fd=%h expected 1 31c0 5678", bus.fill_valid_o, bus.fill_addr_o, bus.fill_data_o);
        end
        drive(0, '0, 8'h04, 4'd10, '0, '0); tick();
        drive(0, '0, 8'h08, 4'd11, '0, '0); tick();
        idle();
        @(negedge clock);
        checks++; if (bus.req_o !== 8'h71) begin errors++; $display("FAIL two_wait_mem: got %h expected 71", bus.req_o); end
        reset = 1'b1; tick(); reset = 1'b0;
        drive(0, '0, '0, '0, 4'd10, 64'h1); tick();
        drive(0, '0, '0, '0, 4'd11, 64'h2);
        @(negedge clock);
        checks++; if (bus.fill_valid_o !== 1'b0) begin errors++; $display("FAIL stale_tag_10: got %b expected 0", bus.fill_valid_o); end
        tick();
        idle();
        @(negedge clock);
        checks++; if (bus.fill_valid_o !== 1'b0 || bus.req_o !== 8'h00 || bus.full_o !== 1'b0) begin
            errors++; $display("FAIL stale_tag_11: got fv=%b req=%h full=%b expected 0 00 0", bus.fill_valid_o, bus.req_o, bus.full_o);
        end
        tick();
    endtask

    task automatic test_dup();
        logic [N-1:0] want;
`ifdef PFETCH_DUP_CHECK_EN
        want = 8'h01;
`else
        want = 8'h03;
`endif
        drive(1, 64'h2000, '0, '0, '0, '0); tick();
        drive(1, 64'h2000, '0, '0, '0, '0); tick();
        idle();
        @(negedge clock);
        checks++; if (bus.req_o !== want) begin errors++; $display("FAIL dup_alloc: got %h expected %h", bus.req_o, want); end
        tick();
    endtask

    task automatic test_random();
        int reqs[$];
        int r;
        logic [N-1:0]      g, er;
        logic [TAG_W-1:0]  t, rt;
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 149) == 0);
            er = exp_req();
            reqs.delete();
            for (int i = 0; i < N; i++) if (er[i]) reqs.push_back(i);
            r = $urandom_range(0, 9);
            g = '0;
            if (r < 6 && reqs.size() > 0) g[reqs[$urandom_range(0, reqs.size() - 1)]] = 1'b1;
            else if (r >= 8) g[$urandom_range(0, N - 1)] = 1'b1;
            t = '0;
            if ($urandom_range(0, 4) != 0) begin
                for (int k = 0; k < 32 && t == 0; k++) begin
                    rt = TAG_W'($urandom_range(1, 15));
                    if (!tag_live(rt)) t = rt;
                end
            end
            rt = '0;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                for (int i = 0; i < N; i++) if (m_busy[i] && m_issued[i] && $urandom_range(0, 1) == 1) rt = m_tag[i];
            end else if (r >= 7) rt = TAG_W'($urandom_range(1, 15));
            drive($urandom_range(0, 2) != 0, 64'($urandom_range(0, 15)) << 6, g, t, rt, {$urandom, $urandom});
            @(negedge clock);
            checks++; if (bus.req_o !== exp_req()) begin errors++; $display("FAIL rnd_req @%0d: got %h expected %h", cyc, bus.req_o, exp_req()); end
            checks++; if (bus.full_o !== exp_full()) begin errors++; $display("FAIL rnd_full @%0d: got %b expected %b", cyc, bus.full_o, exp_full()); end
            checks++; if (bus.ptr_o !== PTR_W'(m_ptr)) begin errors++; $display("FAIL rnd_ptr @%0d: got %0d expected %0d", cyc, bus.ptr_o, m_ptr); end
            checks++; if (bus.mem_cmd_valid_o !== |(bus.gnt_i & exp_req())) begin
                errors++; $display("FAIL rnd_cmd_valid @%0d: got %b expected %b", cyc, bus.mem_cmd_valid_o, |(bus.gnt_i & exp_req()));
            end
            if (|(bus.gnt_i & exp_req())) begin
                checks++; if (bus.mem_addr_o !== exp_mem_addr()) begin errors++; $display("FAIL rnd_mem_addr @%0d: got %h expected %h", cyc, bus.mem_addr_o, exp_mem_addr()); end
            end
            checks++; if (bus.fill_valid_o !== e_fill_valid) begin errors++; $display("FAIL rnd_fill_valid @%0d: got %b expected %b", cyc, bus.fill_valid_o, e_fill_valid); end
            checks++; if (bus.fill_addr_o !== e_fill_addr || bus.fill_data_o !== e_fill_data) begin
                errors++; $display("FAIL rnd_fill @%0d: got a=%h d=%h expected a=%h d=%h", cyc, bus.fill_addr_o, bus.fill_data_o, e_fill_addr, e_fill_data);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        clear_model();
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_tag_zero();
        test_unknown_tag();
        test_dup();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pfetch_req_buf.md
# pfetch_req_buf

Eight-entry prefetch request buffer that sits between the instruction prefetcher and the memory port, on the requester side of the round-robin prefetch-entry selector. It holds outstanding prefetch addresses and drives the selector's request vector and rotating pointer. It consumes the one-hot grant, issues the granted entry's address to memory and tracks the returned memory tag. It retires each entry when the matching response arrives, delivering a registered fill to the I-cache.

## Interface
- NUM_ENTRIES, 8: buffer depth; equals selector width.
- PTR_W, $clog2(NUM_ENTRIES): pointer width.
- ADDR_W, 64: address width.
- DATA_W, 64: memory data width.
- TAG_W, 4: memory tag width; tag 0 means "not accepted / no response".
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- alloc_en_i  in  1  prefetcher requests allocation.
- alloc_addr_i  in  ADDR_W  address to prefetch.
- full_o  out  1  no INVALID entry this cycle.
- req_o  out  NUM_ENTRIES  bit i = entry i in WAIT_GNT.
- ptr_o  out  PTR_W  highest-priority index for the selector.
- gnt_i  in  NUM_ENTRIES  one-hot or zero grant from the selector (same cycle as req_o).
- mem_cmd_valid_o  out  1  memory load command valid.
- mem_addr_o  out  ADDR_W  address of granted entry.
- mem_tag_i  in  TAG_W  nonzero = command accepted with this tag (same cycle).
- mem_resp_tag_i  in  TAG_W  response tag; 0 = none.
- mem_resp_data_i  in  DATA_W  response data.
- fill_valid_o  out  1  registered fill strobe.
- fill_addr_o  out  ADDR_W  fill address.
- fill_data_o  out  DATA_W  fill data.

## Operation
- Per-entry state: INVALID, WAIT_GNT (address held, requesting), WAIT_MEM (tag held, awaiting response).
- INVALID -> WAIT_GNT: when alloc_en_i && !full_o, the lowest-index INVALID entry captures alloc_addr_i.
- WAIT_GNT -> WAIT_MEM: entry i has gnt_i[i]=1 and req_o[i]=1 and mem_tag_i!=0; capture mem_tag_i. If mem_tag_i==0, the entry stays in WAIT_GNT and ptr_o is unchanged.
- WAIT_MEM -> INVALID: mem_resp_tag_i!=0 equals the stored tag. The matching entry is freed. Fill outputs register {1, addr, mem_resp_data_i}. At most one entry matches, because the memory never reissues a live tag.
- mem_cmd_valid_o = |(gnt_i & req_o). mem_addr_o = address of that entry (combinational mux). Grant bits not set in req_o are ignored. A grant with more than one bit set is a protocol error, and behaviour is undefined.
- ptr_o: on an accepted issue from entry i, ptr_o <= (i+1) mod NUM_ENTRIES, wrapping from NUM_ENTRIES-1 to 0. Otherwise ptr_o holds.
- full_o is computed from current-cycle state only. A slot freed this cycle becomes allocatable next cycle.
- Simultaneous alloc, issue and response on different entries all take effect in the same cycle. An entry cannot be both allocated and issued in one cycle, because req_o reflects registered state.
- A response with an unmatched tag is dropped, and fill_valid_o stays 0.

## Timing
- Reset: every entry INVALID, ptr_o=0, req_o=0, full_o=0, mem_cmd_valid_o=0, fill_valid_o=0, fill_addr_o=0, fill_data_o=0.
- Reset mid-operation: all outstanding entries are discarded. Later responses carrying old tags match nothing and are dropped.
- Alloc at cycle t -> req_o bit set at t+1 -> earliest issue at t+1.
- Response at cycle r -> fill_valid_o=1 at r+1 for exactly one cycle, unless another response arrives at r+1.
- Minimum alloc-to-fill latency is 3 cycles plus the memory latency.

## Configuration
- PFETCH_DUP_CHECK_EN defined: an alloc whose address equals any non-INVALID entry's address, or equals the fill being retired this cycle, is dropped silently. It allocates nothing and is not back-pressured.
- Undefined: duplicates allocate separate entries and each issues its own memory command.

## Test plan
- Reset, then alloc 0x1000 at cycle 1, gnt_i=8'h01 with mem_tag_i=3 at cycle 2 -> req_o=8'h01 at cycle 2. mem_cmd_valid_o=1 with mem_addr_o=0x1000, then ptr_o=1 at cycle 3. A response with tag 3 at cycle 5 -> fill_valid_o=1 with fill_addr_o=0x1000 at cycle 6, and the entry returns to INVALID.
- Allocate 8 entries -> full_o=1. A 9th alloc is ignored. Retire one entry -> full_o=0 the cycle after.
- Grant to entry 7 accepted -> ptr_o wraps to 0.
- Grant with mem_tag_i=0 -> no state change: entry still requesting, ptr_o held.
- Response with an unknown tag 9 -> fill_valid_o=0 and no entry freed. Assert reset while two entries are in WAIT_MEM, then send their tags -> no fill.
- Alloc 0x2000 twice -> one entry with PFETCH_DUP_CHECK_EN defined, two entries without it.
